// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding memory request engine feeding a
// 2-entry {PC, instruction} buffer toward decode, with branch redirect/flush.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic [6:0]  Opcode
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state, state_next;
  logic        req, req_next;
  logic [31:0] addr, addr_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] redirect_pc;
  logic        push, pop;

  logic [31:0] fifo_pc  [2];
  logic [31:0] fifo_ins [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  assign redirect_pc = BranchTarget & 32'hFFFF_FFFC;
  assign pop         = (count != 2'd0) && InstrReady;

  always_comb begin
    state_next    = state;
    req_next      = req;
    addr_next     = addr;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (!PCSrc && (count <= 2'd1)) begin
          state_next = FETCH;
          req_next   = 1'b1;
          addr_next  = fetch_pc;
        end
      end
      FETCH: begin
        if (IMemAck) begin
          req_next   = 1'b0;
          state_next = IDLE;
          if (!PCSrc) begin
            push          = 1'b1;
            fetch_pc_next = addr + 32'd4;
          end
        end else if (PCSrc) begin
          // keep the request on the bus until memory answers, then drop it
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (IMemAck) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (PCSrc) fetch_pc_next = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= 32'd0;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      req      <= req_next;
      addr     <= addr_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // buffer occupancy; a redirect flushes after any same-cycle pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (PCSrc) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count  <= count + 2'd1;
          wr_ptr <= ~wr_ptr;
        end
        2'b01: begin
          count  <= count - 2'd1;
          rd_ptr <= ~rd_ptr;
        end
        2'b11: begin
          wr_ptr <= ~wr_ptr;
          rd_ptr <= ~rd_ptr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= addr;
      fifo_ins[wr_ptr] <= IMemRData;
    end
  end

  assign IMemReq     = req;
  assign IMemAddr    = addr;
  assign InstrValid  = (count != 2'd0);
  assign Instruction = InstrValid ? fifo_ins[rd_ptr] : 32'd0;
  assign InstrPC     = InstrValid ? fifo_pc[rd_ptr]  : 32'd0;
  assign Opcode      = Instruction[6:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a simple zero-wait memory model
// whose acknowledge can be enabled, withheld or forced from the test tasks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic [6:0]  Opcode;

  logic ack_en;
  logic ack_force;
  int   tests = 0;
  int   fails = 0;

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemRData    (IMemRData),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Instruction  (Instruction),
    .InstrPC      (InstrPC),
    .Opcode       (Opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hC3, a[25:2]} ^ 32'h0000_0013;
  endfunction

  always_comb begin
    IMemAck   = ack_force | (ack_en & IMemReq);
    IMemRData = mem_word(IMemAddr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = 32'd0;
    ack_en       = 1'b0;
    ack_force    = 1'b0;
    InstrReady   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({IMemReq, InstrValid} !== 2'b00) begin
      fails++; $display("FAIL reset_ctrl: req/valid=%b expected 00", {IMemReq, InstrValid});
    end
    tests++;
    if ({IMemAddr, Instruction, InstrPC, Opcode} !== 103'd0) begin
      fails++; $display("FAIL reset_data: addr=%h instr=%h pc=%h op=%h expected all 0",
                        IMemAddr, Instruction, InstrPC, Opcode);
    end
  endtask

  task automatic test_stream();
    logic [6:0] ops [3];
    ops[0] = 7'h13; ops[1] = 7'h12; ops[2] = 7'h11;
    do_reset();
    ack_en = 1'b1;
    InstrReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (IMemReq !== 1'b1 || IMemAddr !== 32'(4 * k)) begin
        fails++; $display("FAIL stream_req%0d: req=%b addr=%h expected 1 %h", k, IMemReq, IMemAddr, 32'(4 * k));
      end
      step();
      tests++;
      if (InstrValid !== 1'b1 || InstrPC !== 32'(4 * k) || Instruction !== mem_word(32'(4 * k))) begin
        fails++; $display("FAIL stream_out%0d: valid=%b pc=%h instr=%h expected 1 %h %h",
                          k, InstrValid, InstrPC, Instruction, 32'(4 * k), mem_word(32'(4 * k)));
      end
      tests++;
      if (Opcode !== ops[k]) begin
        fails++; $display("FAIL stream_op%0d: opcode=%h expected %h", k, Opcode, ops[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_en = 1'b1;
    repeat (4) step();
    tests++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h0 || Instruction !== 32'hC300_0013) begin
      fails++; $display("FAIL bp_head: valid=%b pc=%h instr=%h expected 1 0 c3000013", InstrValid, InstrPC, Instruction);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (IMemReq !== 1'b0 || InstrPC !== 32'h0) begin
        fails++; $display("FAIL bp_hold%0d: req=%b pc=%h expected 0 0", i, IMemReq, InstrPC);
      end
    end
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    tests++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b1 || InstrPC !== 32'h4) begin
      fails++; $display("FAIL bp_pop: req=%b valid=%b pc=%h expected 0 1 4", IMemReq, InstrValid, InstrPC);
    end
    step();
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin
      fails++; $display("FAIL bp_third: req=%b addr=%h expected 1 8", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_drain();
    do_reset();
    ack_en = 1'b1;
    InstrReady = 1'b1;
    repeat (4) step();
    tests++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h4) begin
      fails++; $display("FAIL drain_pre: valid=%b pc=%h expected 1 4", InstrValid, InstrPC);
    end
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (IMemReq !== 1'b1 || IMemAddr !== 32'h8 || InstrValid !== 1'b0) begin
        fails++; $display("FAIL drain_wait%0d: req=%b addr=%h valid=%b expected 1 8 0", i, IMemReq, IMemAddr, InstrValid);
      end
    end
    PCSrc = 1'b1;
    BranchTarget = 32'h0000_0103;
    step();
    PCSrc = 1'b0;
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h8 || InstrValid !== 1'b0) begin
      fails++; $display("FAIL drain_hold: req=%b addr=%h valid=%b expected 1 8 0", IMemReq, IMemAddr, InstrValid);
    end
    ack_en = 1'b1;
    step();
    tests++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      fails++; $display("FAIL drain_drop: req=%b valid=%b expected 0 0", IMemReq, InstrValid);
    end
    step();
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h100 || InstrValid !== 1'b0) begin
      fails++; $display("FAIL drain_target: req=%b addr=%h valid=%b expected 1 100 0", IMemReq, IMemAddr, InstrValid);
    end
    step();
    tests++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h100 || Instruction !== 32'hC300_0053) begin
      fails++; $display("FAIL drain_result: valid=%b pc=%h instr=%h expected 1 100 c3000053", InstrValid, InstrPC, Instruction);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    ack_en = 1'b1;
    step();
    PCSrc = 1'b1;
    BranchTarget = 32'h0000_0040;
    step();
    PCSrc = 1'b0;
    tests++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      fails++; $display("FAIL redir_ack_nopush: req=%b valid=%b expected 0 0", IMemReq, InstrValid);
    end
    step();
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h40) begin
      fails++; $display("FAIL redir_ack_req: req=%b addr=%h expected 1 40", IMemReq, IMemAddr);
    end
    step();
    tests++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h40) begin
      fails++; $display("FAIL redir_ack_out: valid=%b pc=%h expected 1 40", InstrValid, InstrPC);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    InstrReady = 1'b1;
    PCSrc = 1'b1;
    BranchTarget = 32'hFFFF_FFFE;
    step();
    PCSrc = 1'b0;
    ack_en = 1'b1;
    step();
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap_req: req=%b addr=%h expected 1 fffffffc", IMemReq, IMemAddr);
    end
    step();
    tests++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap_out: valid=%b pc=%h expected 1 fffffffc", InstrValid, InstrPC);
    end
    step();
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
      fails++; $display("FAIL wrap_next: req=%b addr=%h expected 1 0", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_reset_midrequest();
    do_reset();
    ack_en = 1'b1;
    repeat (4) step();
    tests++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h0) begin
      fails++; $display("FAIL mid_full: valid=%b pc=%h expected 1 0", InstrValid, InstrPC);
    end
    ack_en = 1'b0;
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    step();
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h8 || InstrPC !== 32'h4) begin
      fails++; $display("FAIL mid_pending: req=%b addr=%h pc=%h expected 1 8 4", IMemReq, IMemAddr, InstrPC);
    end
    rst_n = 1'b0;
    step();
    tests++;
    if ({IMemReq, InstrValid, IMemAddr, Instruction, InstrPC, Opcode} !== 105'd0) begin
      fails++; $display("FAIL mid_reset: req=%b valid=%b addr=%h instr=%h pc=%h op=%h expected all 0",
                        IMemReq, InstrValid, IMemAddr, Instruction, InstrPC, Opcode);
    end
    rst_n = 1'b1;
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    ack_en = 1'b1;
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || InstrValid !== 1'b0) begin
      fails++; $display("FAIL mid_restart: req=%b addr=%h valid=%b expected 1 0 0", IMemReq, IMemAddr, InstrValid);
    end
    step();
    tests++;
    if (InstrValid !== 1'b1 || InstrPC !== 32'h0 || Instruction !== 32'hC300_0013) begin
      fails++; $display("FAIL mid_refetch: valid=%b pc=%h instr=%h expected 1 0 c3000013", InstrValid, InstrPC, Instruction);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_midrequest();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
